// File: rtl/lif_pkg.sv
// Shared types, defaults and saturating arithmetic helper for the LIF neuron array.
package lif_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      OUTPUT = 2'd2
   } state_e;

   localparam int unsigned DEF_N_NEURONS         = 4;
   localparam int unsigned DEF_INPUT_WIDTH       = 8;
   localparam int unsigned DEF_POTENTIAL_WIDTH   = 16;
   localparam int          DEF_THRESHOLD         = 300;
   localparam int          DEF_RESET_POTENTIAL   = 0;
   localparam int unsigned DEF_LEAK_SHIFT        = 4;
   localparam int unsigned DEF_REFRACTORY_PERIOD = 4;

   localparam int unsigned SAT_W = 64;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Signed add clamped to the range of a w-bit two's complement value.
   function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                      input logic signed [SAT_W-1:0] b,
                                                      input int unsigned             w);
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      s  = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/lif_neuron_array_if.sv
// Step/spike handshake and potential monitor bundle for lif_neuron_array.
interface lif_neuron_array_if
   import lif_pkg::*;
#(
   parameter int unsigned N_NEURONS       = DEF_N_NEURONS,
   parameter int unsigned INPUT_WIDTH     = DEF_INPUT_WIDTH,
   parameter int unsigned POTENTIAL_WIDTH = DEF_POTENTIAL_WIDTH
) ();
   localparam int unsigned IDX_W = cnt_width(N_NEURONS);

   logic                              step_valid;
   logic                              step_ready;
   logic [N_NEURONS*INPUT_WIDTH-1:0]  current_in;
   logic                              spike_valid;
   logic                              spike_ready;
   logic [N_NEURONS-1:0]              spike_out;
   logic                              busy;
   logic [IDX_W-1:0]                  mon_idx;
   logic signed [POTENTIAL_WIDTH-1:0] mon_potential;

   modport master (
      output step_valid, current_in, spike_ready, mon_idx,
      input  step_ready, spike_valid, spike_out, busy, mon_potential
   );

   modport slave (
      input  step_valid, current_in, spike_ready, mon_idx,
      output step_ready, spike_valid, spike_out, busy, mon_potential
   );
endinterface

// File: rtl/lif_update_unit.sv
// Combinational leak/integrate/saturate/threshold/refractory step for one neuron.
module lif_update_unit
   import lif_pkg::*;
#(
   parameter int unsigned INPUT_WIDTH       = DEF_INPUT_WIDTH,
   parameter int unsigned POTENTIAL_WIDTH   = DEF_POTENTIAL_WIDTH,
   parameter int          THRESHOLD         = DEF_THRESHOLD,
   parameter int          RESET_POTENTIAL   = DEF_RESET_POTENTIAL,
   parameter int unsigned LEAK_SHIFT        = DEF_LEAK_SHIFT,
   parameter int unsigned REFRACTORY_PERIOD = DEF_REFRACTORY_PERIOD,
   parameter int unsigned REFR_W            = cnt_width(REFRACTORY_PERIOD + 1)
) (
   input  logic signed [INPUT_WIDTH-1:0]     cur_i,
   input  logic signed [POTENTIAL_WIDTH-1:0] v_i,
   input  logic        [REFR_W-1:0]          refr_i,
   output logic signed [POTENTIAL_WIDTH-1:0] v_c_o,
   output logic        [REFR_W-1:0]          refr_c_o,
   output logic                              spike_c_o
);
   localparam int unsigned EXT_W = POTENTIAL_WIDTH + 2;

   logic signed [POTENTIAL_WIDTH-1:0] leak;
   logic signed [EXT_W-1:0]           sum;
   logic signed [SAT_W-1:0]           sat;

   always_comb begin
      v_c_o     = POTENTIAL_WIDTH'(RESET_POTENTIAL);
      refr_c_o  = '0;
      spike_c_o = 1'b0;
      leak      = v_i >>> LEAK_SHIFT;
      sum       = EXT_W'(v_i) - EXT_W'(leak) + EXT_W'(cur_i);
      sat       = sat_add(SAT_W'(sum), '0, POTENTIAL_WIDTH);
      if (refr_i != '0) begin
         refr_c_o = refr_i - REFR_W'(1);
      end else if (sat >= SAT_W'(THRESHOLD)) begin
         spike_c_o = 1'b1;
         refr_c_o  = REFR_W'(REFRACTORY_PERIOD);
      end else begin
         v_c_o = POTENTIAL_WIDTH'(sat);
      end
   end
endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of LIF neurons: one shared update unit walks all neurons per step.
module lif_neuron_array
   import lif_pkg::*;
#(
   parameter int unsigned N_NEURONS         = DEF_N_NEURONS,
   parameter int unsigned INPUT_WIDTH       = DEF_INPUT_WIDTH,
   parameter int unsigned POTENTIAL_WIDTH   = DEF_POTENTIAL_WIDTH,
   parameter int          THRESHOLD         = DEF_THRESHOLD,
   parameter int          RESET_POTENTIAL   = DEF_RESET_POTENTIAL,
   parameter int unsigned LEAK_SHIFT        = DEF_LEAK_SHIFT,
   parameter int unsigned REFRACTORY_PERIOD = DEF_REFRACTORY_PERIOD
) (
   input logic               clk,
   input logic               rst_n,
   lif_neuron_array_if.slave bus
);
   localparam int unsigned IDX_W  = cnt_width(N_NEURONS);
   localparam int unsigned REFR_W = cnt_width(REFRACTORY_PERIOD + 1);

   state_e                            state_q, state_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [N_NEURONS-1:0]              spike_q, spike_d;
   logic signed [INPUT_WIDTH-1:0]     cur_q  [N_NEURONS];
   logic signed [POTENTIAL_WIDTH-1:0] v_q    [N_NEURONS];
   logic [REFR_W-1:0]                 refr_q [N_NEURONS];
   logic                              accept;
   logic                              wr_en;
   logic signed [POTENTIAL_WIDTH-1:0] upd_v;
   logic [REFR_W-1:0]                 upd_refr;
   logic                              upd_spike;

   lif_update_unit #(
      .INPUT_WIDTH      (INPUT_WIDTH),
      .POTENTIAL_WIDTH  (POTENTIAL_WIDTH),
      .THRESHOLD        (THRESHOLD),
      .RESET_POTENTIAL  (RESET_POTENTIAL),
      .LEAK_SHIFT       (LEAK_SHIFT),
      .REFRACTORY_PERIOD(REFRACTORY_PERIOD),
      .REFR_W           (REFR_W)
   ) u_update (
      .cur_i    (cur_q[idx_q]),
      .v_i      (v_q[idx_q]),
      .refr_i   (refr_q[idx_q]),
      .v_c_o    (upd_v),
      .refr_c_o (upd_refr),
      .spike_c_o(upd_spike)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         spike_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         spike_q <= spike_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      spike_d = spike_q;
      accept  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.step_valid) begin
               accept  = 1'b1;
               state_d = UPDATE;
               idx_d   = '0;
               spike_d = '0;
            end
         end
         UPDATE: begin
            wr_en          = 1'b1;
            spike_d[idx_q] = upd_spike;
            if (idx_q == IDX_W'(N_NEURONS - 1)) state_d = OUTPUT;
            else                                idx_d   = idx_q + IDX_W'(1);
         end
         OUTPUT: begin
            if (bus.spike_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Neuron state storage: currents latched at acceptance, one neuron rewritten per UPDATE cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_NEURONS); i++) begin
            cur_q[i]  <= '0;
            v_q[i]    <= '0;
            refr_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            for (int i = 0; i < int'(N_NEURONS); i++) begin
               cur_q[i] <= bus.current_in[i*INPUT_WIDTH +: INPUT_WIDTH];
            end
         end
         if (wr_en) begin
            v_q[idx_q]    <= upd_v;
            refr_q[idx_q] <= upd_refr;
         end
      end
   end

   assign bus.step_ready    = (state_q == IDLE);
   assign bus.spike_valid   = (state_q == OUTPUT);
   assign bus.busy          = (state_q != IDLE);
   assign bus.spike_out     = spike_q;
   assign bus.mon_potential = v_q[bus.mon_idx];
endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N leaky integrate-and-fire neurons sharing one update datapath. It is the parametrised successor to the single LIF neuron. It adds a per-step input/output handshake, channel count, configurable reset potential, saturating arithmetic and a potential monitor port. It sits between the spike-encoder front end and the next synaptic layer, and consumes one vector of input currents per simulation time step.

## Interface
- N_NEURONS, 4: neuron count (≥1)
- INPUT_WIDTH, 8: signed input current width per neuron
- POTENTIAL_WIDTH, 16: signed membrane potential width
- THRESHOLD, 300: signed firing threshold, must fit POTENTIAL_WIDTH
- RESET_POTENTIAL, 0: potential loaded after a spike and during refractory
- LEAK_SHIFT, 4: leak term = v >>> LEAK_SHIFT
- REFRACTORY_PERIOD, 4: steps ignored after a spike; 0 disables refractory
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- step_valid  in  1  current vector valid
- step_ready  out  1  array idle and can accept a step
- current_in  in  N_NEURONS*INPUT_WIDTH  packed signed currents; neuron i at [i*INPUT_WIDTH +: INPUT_WIDTH]
- spike_valid  out  1  spike vector valid
- spike_ready  in  1  downstream accepts spike vector
- spike_out  out  N_NEURONS  spike bit per neuron for the completed step
- busy  out  1  high in UPDATE or OUTPUT
- mon_idx  in  $clog2(N_NEURONS)  monitor select
- mon_potential  out  POTENTIAL_WIDTH  combinational read of potential[mon_idx]

## Operation
- FSM states:
  - IDLE: step_ready=1.
  - UPDATE: one neuron per cycle, index 0..N_NEURONS-1.
  - OUTPUT: spike_valid=1.
- Transitions:
  - IDLE→UPDATE on step_valid&&step_ready; current_in is latched on that edge.
  - UPDATE→OUTPUT after index N_NEURONS-1 is written.
  - OUTPUT→IDLE on spike_valid&&spike_ready.
- Per-neuron update when refr>0: refr−1; v=RESET_POTENTIAL; no spike.
- Per-neuron update when refr=0:
  - next = v − (v>>>LEAK_SHIFT) + sext(I).
  - Compute at POTENTIAL_WIDTH+2 bits, then saturate to [−2^(PW−1), 2^(PW−1)−1].
  - If next ≥ THRESHOLD (signed): spike bit=1, v=RESET_POTENTIAL, refr=REFRACTORY_PERIOD.
  - Else v=next, spike bit=0.
- Refractory counter width: $clog2(REFRACTORY_PERIOD+1), with a minimum of 1.
- spike_out is a register, built bit-by-bit during UPDATE and held stable throughout OUTPUT.
- step_valid is ignored outside IDLE; current_in is only sampled at acceptance.

## Timing
- Reset (rst_n low at an edge): state=IDLE, all potentials=0, all refr=0, spike_out=0, spike_valid=0, busy=0, step_ready=1.
- Reset mid-UPDATE or mid-OUTPUT aborts the step entirely; no partial state survives.
- Latency: acceptance at edge E0; neuron i is written at edge E(i+1); spike_valid is high from E(N_NEURONS).
- Throughput: with spike_ready tied high, one step per N_NEURONS+2 cycles, since IDLE lasts one cycle.
- Backpressure: OUTPUT holds spike_out, spike_valid and all potentials indefinitely.
- Handshake rules: spike_valid never drops before spike_ready; both handshakes complete in the same cycle they are asserted.
- mon_potential reflects the register contents; it updates the cycle after a write.

## Structure
- Package lif_pkg:
  - state enum (IDLE/UPDATE/OUTPUT).
  - sat_add helper function.
  - default parameter constants.
- Sub-module lif_update_unit: combinational leak/integrate/saturate/threshold/refractory for one neuron. It is instantiated once; the array owns state storage, the FSM and the index counter.

## Test plan
- Ramp: all currents 64, spike_ready=1.
  - Neuron 0 potentials per step: 64, 124, 181, 234, 284, then spike on step 6 with v=0.
  - Steps 7–10: no spike, v=0.
  - Step 11: v=64.
- Strong drive: current 127.
  - Potentials 127, 247.
  - Spike on step 3.
- Saturation: instance with POTENTIAL_WIDTH=10, current −128.
  - Potentials 0→−128, −248, −360, −465.
  - −512 on step 5, stays at −512 thereafter.
- Independence: currents {127,0,−64,64}, three steps.
  - Step 3: spike_out=4'b0001.
  - Neuron 2 potential negative; neuron 1 potential 0.
- Backpressure: hold spike_ready=0 for 20 cycles while pulsing step_valid.
  - spike_valid and spike_out stay stable; step_ready=0.
  - No potential change.
  - After release, the next step is accepted normally.
- Reset mid-step: drive rst_n=0 for one cycle during UPDATE index 1.
  - Next cycle: IDLE, all potentials 0, spike_valid=0.
  - The following step with current 64 gives v=64.
